// File: rtl/alu_ctrl_mc.sv
// alu_ctrl_mc: ALU control decode plus a multi-cycle multiply/divide sequencer with HI/LO interlock.
// Ports:
//   clk, rst_n           clock and asynchronous active-low reset
//   issue, flush         instruction valid this cycle, abort any multiply/divide sequence
//   funct[5:0]           R-type function field
//   ALUOp[2:0]           main-control ALU class (110 selects R-type decode)
//   OP[3:0], JR, shamt   combinational ALU select, jump-register flag, shift-amount-source flag
//   stall                hold the issuing stage (MD/HILO op presented while a sequence runs)
//   md_start, md_op[1:0] launch pulse and registered funct[1:0] of the accepted op
//   hilo_we, md_busy     HI/LO write-enable pulse, sequence in progress
module alu_ctrl_mc #(
    parameter int MUL_CYCLES = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       issue,
    input  logic       flush,
    input  logic [5:0] funct,
    input  logic [2:0] ALUOp,
    output logic [3:0] OP,
    output logic       JR,
    output logic       shamt,
    output logic       stall,
    output logic       md_start,
    output logic [1:0] md_op,
    output logic       hilo_we,
    output logic       md_busy
);
    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAXC);
    // Loading N-2 accounts for the accept edge and the DONE cycle, giving N cycles accept-to-hilo_we.
    localparam logic [CW-1:0] MUL_LD = CW'(MUL_CYCLES - 2);
    localparam logic [CW-1:0] DIV_LD = CW'(DIV_CYCLES - 2);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          r_state, w_next;
    logic [CW-1:0]   r_cnt, w_cnt;
    logic            r_start;
    logic [1:0]      r_md_op;
    logic            w_rtype, w_md, w_hilo, w_accept;
    logic [3:0]      w_rdec;

    assign w_rtype  = ALUOp == 3'b110;
    assign w_md     = issue && w_rtype && funct[5:2] == 4'b0110;
    assign w_hilo   = issue && w_rtype && funct[5:2] == 4'b0100;
    assign w_accept = r_state == IDLE && w_md && !flush;

    always_comb begin
        case (funct)
            6'b100000: w_rdec = 4'b0000;
            6'b100010: w_rdec = 4'b0001;
            6'b100100: w_rdec = 4'b0011;
            6'b100111: w_rdec = 4'b0100;
            6'b100101: w_rdec = 4'b0101;
            6'b100110: w_rdec = 4'b0110;
            6'b000000: w_rdec = 4'b0111;
            6'b000100: w_rdec = 4'b1000;
            6'b000010: w_rdec = 4'b1001;
            6'b000110: w_rdec = 4'b1010;
            6'b000011: w_rdec = 4'b1100;
            6'b000111: w_rdec = 4'b1101;
            6'b101010: w_rdec = 4'b1110;
            6'b101011: w_rdec = 4'b1111;
            default:   w_rdec = 4'b0000;
        endcase
    end

    always_comb begin
        case (ALUOp)
            3'b000:  OP = 4'b0000;
            3'b001:  OP = 4'b0001;
            3'b010:  OP = 4'b0011;
            3'b011:  OP = 4'b0101;
            3'b100:  OP = 4'b0110;
            3'b101:  OP = 4'b1110;
            3'b111:  OP = 4'b1111;
            default: OP = w_rdec;
        endcase
    end

    assign JR       = w_rtype && funct == 6'b001000;
    assign shamt    = w_rtype && (funct == 6'b000000 || funct == 6'b000010 || funct == 6'b000011);
    assign stall    = r_state != IDLE && (w_md || w_hilo);
    assign md_busy  = r_state != IDLE;
    // Flush wins over any pulse due this cycle, including the DONE write.
    assign md_start = r_start && !flush;
    assign hilo_we  = r_state == DONE && !flush;
    assign md_op    = r_md_op;

    always_comb begin
        w_next = r_state;
        w_cnt  = r_cnt;
        if (flush) begin
            w_next = IDLE;
            w_cnt  = '0;
        end else begin
            case (r_state)
                IDLE: if (w_md) begin
                    w_next = BUSY;
                    w_cnt  = funct[1] ? DIV_LD : MUL_LD;
                end
                BUSY: if (r_cnt == '0) w_next = DONE;
                      else w_cnt = r_cnt - 1'b1;
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_start <= 1'b0;
            r_md_op <= 2'b00;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt;
            r_start <= w_accept;
            if (w_accept) r_md_op <= funct[1:0];
        end
    end
endmodule

// File: tb/tb_alu_ctrl_mc.sv
// tb_alu_ctrl_mc: scoreboard bench for alu_ctrl_mc at default and MUL=2/DIV=64 parameters.
module tb_alu_ctrl_mc;
    typedef struct { int cyc; bit hilo; logic [1:0] op; } ev_t;
    typedef struct { logic [3:0] op; bit jr, sh, st, busy, rst; } cb_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       issue = 1'b0;
    logic       flush = 1'b0;
    logic [5:0] funct = '0;
    logic [2:0] aluop = '0;
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // Reference decode straight from the opcode tables.
    function automatic logic [3:0] ref_op(input logic [2:0] a, input logic [5:0] f);
        case (a)
            3'd0: return 4'd0;
            3'd1: return 4'd1;
            3'd2: return 4'd3;
            3'd3: return 4'd5;
            3'd4: return 4'd6;
            3'd5: return 4'd14;
            3'd7: return 4'd15;
            default: case (f)
                6'd32: return 4'd0;  6'd34: return 4'd1;  6'd36: return 4'd3;
                6'd39: return 4'd4;  6'd37: return 4'd5;  6'd38: return 4'd6;
                6'd0:  return 4'd7;  6'd4:  return 4'd8;  6'd2:  return 4'd9;
                6'd6:  return 4'd10; 6'd3:  return 4'd12; 6'd7:  return 4'd13;
                6'd42: return 4'd14; 6'd43: return 4'd15;
                default: return 4'd0;
            endcase
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int MC = g ? 2 : 32;
        localparam int DC = g ? 64 : 32;
        logic [3:0] op;
        logic       jr, sh, st, ms, hw, mb;
        logic [1:0] mo;
        ev_t        evq[$];
        cb_t        cbq[$];
        int         acc = -1;
        int         due = -1;

        alu_ctrl_mc #(.MUL_CYCLES(MC), .DIV_CYCLES(DC)) u_dut (
            .clk(clk), .rst_n(rst_n), .issue(issue), .flush(flush), .funct(funct),
            .ALUOp(aluop), .OP(op), .JR(jr), .shamt(sh), .stall(st), .md_start(ms),
            .md_op(mo), .hilo_we(hw), .md_busy(mb)
        );

        // Predictor: a sequence accepted in cycle acc occupies cycles acc+1..acc+N,
        // with md_start at acc+1 and hilo_we at acc+N, unless flushed or reset first.
        always @(posedge clk) begin : pred
            int  c;
            bit  busy, md, hl;
            cb_t r;
            #2;
            c    = cyc;
            busy = rst_n && acc < c && c <= due;
            md   = issue && aluop == 3'd6 && funct inside {[6'd24:6'd27]};
            hl   = issue && aluop == 3'd6 && funct inside {[6'd16:6'd19]};
            r.op   = ref_op(aluop, funct);
            r.jr   = aluop == 3'd6 && funct == 6'd8;
            r.sh   = aluop == 3'd6 && funct inside {6'd0, 6'd2, 6'd3};
            r.st   = busy && (md || hl);
            r.busy = busy;
            r.rst  = !rst_n;
            cbq.push_back(r);
            if (!rst_n || flush) begin
                while (evq.size() > 0 && evq[$].cyc >= c) void'(evq.pop_back());
                due = -1;
            end else if (!busy && md) begin
                acc = c;
                due = c + (funct[1] ? DC : MC);
                evq.push_back('{c + 1, 1'b0, funct[1:0]});
                evq.push_back('{due, 1'b1, funct[1:0]});
            end
        end

        always @(negedge clk) if (cyc > 0) begin : mon
            cb_t r;
            ev_t e;
            chk($sformatf("i%0d_cb_queue_depth", g), cbq.size(), 1);
            if (cbq.size() > 0) begin
                r = cbq.pop_front();
                chk($sformatf("i%0d_OP", g), op, r.op);
                chk($sformatf("i%0d_JR", g), jr, r.jr);
                chk($sformatf("i%0d_shamt", g), sh, r.sh);
                chk($sformatf("i%0d_stall", g), st, r.st);
                chk($sformatf("i%0d_md_busy", g), mb, r.busy);
                if (r.rst) chk($sformatf("i%0d_md_op_reset", g), mo, 0);
            end
            while (evq.size() > 0 && evq[0].cyc < cyc) begin
                e = evq.pop_front();
                chk($sformatf("i%0d_missed_event_cycle", g), cyc, e.cyc);
            end
            if (evq.size() > 0 && evq[0].cyc == cyc) begin
                e = evq.pop_front();
                chk($sformatf("i%0d_md_start", g), ms, !e.hilo);
                chk($sformatf("i%0d_hilo_we", g), hw, e.hilo);
                chk($sformatf("i%0d_md_op", g), mo, e.op);
            end else begin
                chk($sformatf("i%0d_md_start_idle", g), ms, 0);
                chk($sformatf("i%0d_hilo_we_idle", g), hw, 0);
            end
        end
    end

    task automatic step(input bit i, input bit f, input bit rn, input logic [2:0] a,
                        input logic [5:0] fn, input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            issue = i;
            flush = f;
            rst_n = rn;
            aluop = a;
            funct = fn;
        end
    endtask

    logic [5:0] sweep[18] = '{6'd32, 6'd34, 6'd36, 6'd39, 6'd37, 6'd38, 6'd0, 6'd4, 6'd2,
                              6'd6, 6'd3, 6'd7, 6'd42, 6'd43, 6'd8, 6'd63, 6'd21, 6'd9};

    initial begin
        step(0, 0, 0, 3'd0, 6'd0, 3);
        for (int a = 0; a < 8; a++)
            for (int k = 0; k < 18; k++) step(1, 0, 1, 3'(a), sweep[k]);
        step(1, 0, 1, 3'd6, 6'd24);
        step(0, 0, 1, 3'd0, 6'd0, 40);
        step(1, 0, 1, 3'd6, 6'd27);
        step(0, 0, 1, 3'd0, 6'd0, 4);
        step(1, 0, 1, 3'd6, 6'd18, 10);
        step(1, 0, 1, 3'd6, 6'd32);
        step(1, 0, 1, 3'd6, 6'd18, 60);
        step(0, 0, 1, 3'd0, 6'd0, 70);
        step(1, 0, 1, 3'd6, 6'd26);
        step(0, 0, 1, 3'd0, 6'd0, 9);
        step(0, 1, 1, 3'd0, 6'd0);
        step(1, 0, 1, 3'd6, 6'd24);
        step(0, 0, 1, 3'd0, 6'd0, 70);
        step(1, 0, 1, 3'd6, 6'd24);
        step(0, 0, 1, 3'd0, 6'd0, 6);
        step(0, 0, 0, 3'd0, 6'd0, 2);
        step(0, 0, 1, 3'd0, 6'd0, 40);
        step(1, 0, 1, 3'd6, 6'd24, 80);
        step(0, 0, 1, 3'd0, 6'd0, 70);
        repeat (3000) begin
            int sel;
            logic [5:0] fn;
            sel = $urandom_range(0, 2);
            fn = sel == 0 ? 6'(24 + $urandom_range(0, 3)) :
                 sel == 1 ? 6'(16 + $urandom_range(0, 3)) : 6'($urandom_range(0, 63));
            step(1'($urandom_range(0, 1)), $urandom_range(0, 29) == 0, $urandom_range(0, 199) != 0,
                 $urandom_range(0, 1) ? 3'd6 : 3'($urandom_range(0, 7)), fn);
        end
        step(0, 0, 1, 3'd0, 6'd0, 70);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
